arith_seq: RTL and testbench
============================

ARITH_SEQ -- requirements
Module: arith_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 Parameter XLEN, default 32, SHALL set the operand and result width.
REQ-003 Parameter CHUNK, default 8, SHALL set the adder slice width; XLEN SHALL be an integer multiple of CHUNK, and N = XLEN/CHUNK.
REQ-004 The block SHALL have the following ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- flush, input, 1: abort the current operation.
- in_valid, input, 1: operation offered.
- in_ready, output, 1: block can accept an operation.
- op, input, 3: operation code.
- c16, input, 1: current instruction is 16-bit.
- src1, input, XLEN: operand 1.
- src2, input, XLEN: operand 2.
- now_pc, input, XLEN: PC of the instruction.
- out_valid, output, 1: results available.
- out_ready, input, 1: consumer accepts results.
- arith_result, output, XLEN: main adder result.
- branch_result, output, XLEN: target adder result.
- arith_ovf, output, 1: signed overflow of the main adder (present only per REQ-021).

Function
REQ-005 Operations SHALL be decoded from op as follows (inc = 2 if c16 is 1, else 4):
- 000 ADD: main = src1+src2; target = 0.
- 001 SUB: main = src1 + ~src2 + 1; target = 0.
- 010 BR: main = src1+inc; target = src1+src2.
- 011 JALR: main = now_pc+inc; target = (src1+src2) with bit 0 forced to 0.
- 100 INC: main = src1+1; target = src2+1.
- 101–111: treated as ADD.
REQ-006 The block SHALL implement the FSM states IDLE, COMP and DONE.
REQ-007 in_ready SHALL be 1 only in IDLE; an acceptance occurs at a clock edge where in_valid && in_ready && !flush.
REQ-008 On acceptance, both adder operand pairs, the carry-ins (1 for SUB, 0 otherwise), c16 and op SHALL be latched, the slice counter SHALL be set to 0, and the state SHALL go to COMP.
REQ-009 Each COMP cycle, both adders SHALL process slice k (bits k*CHUNK+CHUNK-1 : k*CHUNK) with the carry registered from slice k-1, then increment k.
REQ-010 After slice N-1 is processed, the state SHALL go to DONE, arith_result and branch_result SHALL load the completed sums, and out_valid SHALL be 1.
- out_valid therefore rises exactly N cycles after the accepting edge.
REQ-011 Outputs SHALL update only when entering DONE and SHALL otherwise hold their last value; partial sums SHALL never be visible.
REQ-012 In DONE, out_valid SHALL stay 1 and the results SHALL stay stable until an edge with out_ready = 1; the state SHALL then go to IDLE.
- No new acceptance is possible on that edge.
REQ-013 Carry out of the MSB SHALL be discarded, so results wrap modulo 2^XLEN.
REQ-014 flush = 1 at any edge SHALL force IDLE and out_valid = 0.
- Results hold their prior values.
- flush SHALL take priority over a simultaneous acceptance and over a simultaneous out_ready.
REQ-015 When CHUNK = XLEN, latency SHALL be 1 cycle with identical handshake behaviour.

Reset
REQ-016 While rst = 1 at an edge, state SHALL become IDLE and out_valid SHALL become 0.
REQ-017 Reset SHALL clear arith_result, branch_result, arith_ovf, the slice counter and the carries to 0.
REQ-018 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-019 Reset SHALL take priority over flush and over all handshakes, including during COMP or DONE.

Configuration
REQ-020 The macro ARITH_SEQ_OVF_EN SHALL control signed-overflow reporting.
REQ-021 With ARITH_SEQ_OVF_EN defined:
- The arith_ovf port SHALL exist.
- On entering DONE it SHALL load (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the effective second operand of the main adder (~src2 for SUB).
- It SHALL hold with the results.
REQ-022 Without ARITH_SEQ_OVF_EN, the arith_ovf port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification (XLEN=32, CHUNK=8, N=4 unless stated)
REQ-023 The bench SHALL cover the following scenarios:
- ADD 0xFFFFFFFF + 0x00000001 -> out_valid 4 cycles after acceptance; arith_result = 0x00000000; arith_ovf = 0; exercises the carry ripple across all slices.
- SUB 0x80000000 - 0x00000001 -> arith_result = 0x7FFFFFFF; arith_ovf = 1; branch_result = 0.
- JALR with c16 = 1, now_pc = 0x100, src1 = 0x203, src2 = 0x10 -> arith_result = 0x102; branch_result = 0x212.
- DONE with out_ready held 0 for 3 cycles -> out_valid = 1, results stable, in_ready = 0; on out_ready = 1 the next cycle is IDLE with in_ready = 1.
- flush on the 2nd COMP cycle, and separately rst in COMP -> IDLE next cycle, out_valid never asserts; after flush the results keep their prior values, after rst the results are 0.
- CHUNK = 32, INC src1 = 0x7FFFFFFF, src2 = 0xFFFFFFFF -> 1-cycle latency; arith_result = 0x80000000; branch_result = 0; arith_ovf = 1.

Source files
------------

// File: rtl/arith_seq.sv
// arith_seq -- sequential slice-by-slice adder pair.
//
// Two XLEN-bit adders (main and branch target) are evaluated CHUNK bits per
// clock, least significant slice first, with the carry held in a register
// between slices. A result is presented N = XLEN/CHUNK cycles after the
// operation is accepted and is held until the consumer takes it.
//
// Optional feature: define ARITH_SEQ_OVF_EN to add the arith_ovf port
// (signed overflow of the main adder). Without it the port is absent.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   flush         abort the current operation (returns to IDLE)
//   in_valid      operation offered
//   in_ready      block can accept an operation (IDLE only)
//   op            operation code: ADD/SUB/BR/JALR/INC, 101-111 act as ADD
//   c16           current instruction is 16-bit (link increment 2 vs 4)
//   src1, src2    operands
//   now_pc        PC of the instruction
//   out_valid     results available
//   out_ready     consumer accepts results
//   arith_result  main adder result
//   branch_result target adder result
//   arith_ovf     signed overflow of main adder (ARITH_SEQ_OVF_EN only)
module arith_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            c16,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] now_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] arith_result,
  output logic [XLEN-1:0] branch_result
`ifdef ARITH_SEQ_OVF_EN
  ,
  output logic            arith_ovf
`endif
);

  localparam int N     = XLEN / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_JALR = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;

`ifdef ARITH_SEQ_OVF_EN
  // Signed overflow: same-sign operands producing a differently-signed sum.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
`endif

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  logic             c16_r;
  logic [XLEN-1:0]  a1_r, b1_r, a2_r, b2_r;
  logic [XLEN-1:0]  sum1_r, sum2_r;
  logic             carry1_r, carry2_r;

  logic [XLEN-1:0]  nx_a1_s, nx_b1_s, nx_a2_s, nx_b2_s;
  logic             nx_cin_s;
  logic [XLEN-1:0]  b1_eff_s;
  logic [31:0]      base_s;
  logic [CHUNK:0]   slice1_s, slice2_s;
  logic [XLEN-1:0]  full1_s, full2_s;
  logic             last_s;

  // Operand selection for an offered operation (latched on acceptance).
  // For BR/JALR the main adder's second operand is the link increment,
  // which is rebuilt from the latched op/c16 below, so b1 is stored as 0.
  always_comb begin
    nx_a1_s  = src1;
    nx_b1_s  = src2;
    nx_a2_s  = {XLEN{1'b0}};
    nx_b2_s  = {XLEN{1'b0}};
    nx_cin_s = 1'b0;
    case (op)
      OP_ADD: begin
        nx_b1_s = src2;
      end
      OP_SUB: begin
        nx_b1_s  = ~src2;
        nx_cin_s = 1'b1;
      end
      OP_BR: begin
        nx_b1_s = {XLEN{1'b0}};
        nx_a2_s = src1;
        nx_b2_s = src2;
      end
      OP_JALR: begin
        nx_a1_s = now_pc;
        nx_b1_s = {XLEN{1'b0}};
        nx_a2_s = src1;
        nx_b2_s = src2;
      end
      OP_INC: begin
        nx_b1_s = XLEN'(32'd1);
        nx_a2_s = src2;
        nx_b2_s = XLEN'(32'd1);
      end
      default: begin
        nx_b1_s = src2;
      end
    endcase
  end

  // Effective second operand of the main adder.
  always_comb begin
    b1_eff_s = b1_r;
    case (op_r)
      OP_BR, OP_JALR: b1_eff_s = c16_r ? XLEN'(32'd2) : XLEN'(32'd4);
      default:        b1_eff_s = b1_r;
    endcase
  end

  // Current slice of both adders, and the completed sums with that slice
  // merged in (used only when the last slice is being processed).
  always_comb begin
    base_s   = 32'(cnt_r) * 32'(CHUNK);
    slice1_s = {1'b0, a1_r[base_s +: CHUNK]} + {1'b0, b1_eff_s[base_s +: CHUNK]}
             + {{CHUNK{1'b0}}, carry1_r};
    slice2_s = {1'b0, a2_r[base_s +: CHUNK]} + {1'b0, b2_r[base_s +: CHUNK]}
             + {{CHUNK{1'b0}}, carry2_r};
    full1_s  = sum1_r;
    full2_s  = sum2_r;
    full1_s[base_s +: CHUNK] = slice1_s[CHUNK-1:0];
    full2_s[base_s +: CHUNK] = slice2_s[CHUNK-1:0];
    if (cnt_r == CNT_W'(N - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM, slice datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      op_r          <= 3'b000;
      c16_r         <= 1'b0;
      a1_r          <= {XLEN{1'b0}};
      b1_r          <= {XLEN{1'b0}};
      a2_r          <= {XLEN{1'b0}};
      b2_r          <= {XLEN{1'b0}};
      sum1_r        <= {XLEN{1'b0}};
      sum2_r        <= {XLEN{1'b0}};
      carry1_r      <= 1'b0;
      carry2_r      <= 1'b0;
      arith_result  <= {XLEN{1'b0}};
      branch_result <= {XLEN{1'b0}};
`ifdef ARITH_SEQ_OVF_EN
      arith_ovf     <= 1'b0;
`endif
    end else if (flush) begin
      // Abort: results keep whatever was last delivered.
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a1_r     <= nx_a1_s;
            b1_r     <= nx_b1_s;
            a2_r     <= nx_a2_s;
            b2_r     <= nx_b2_s;
            carry1_r <= nx_cin_s;
            carry2_r <= 1'b0;
            op_r     <= op;
            c16_r    <= c16;
            cnt_r    <= {CNT_W{1'b0}};
            state_r  <= COMP;
            in_ready <= 1'b0;
          end
        end
        COMP: begin
          sum1_r[base_s +: CHUNK] <= slice1_s[CHUNK-1:0];
          sum2_r[base_s +: CHUNK] <= slice2_s[CHUNK-1:0];
          carry1_r <= slice1_s[CHUNK];
          carry2_r <= slice2_s[CHUNK];
          if (last_s) begin
            // Carry out of the MSB slice is dropped: results wrap.
            state_r      <= DONE;
            out_valid    <= 1'b1;
            arith_result <= full1_s;
            if (op_r == OP_JALR) begin
              branch_result <= {full2_s[XLEN-1:1], 1'b0};
            end else begin
              branch_result <= full2_s;
            end
`ifdef ARITH_SEQ_OVF_EN
            arith_ovf <= ovf_calc(a1_r[XLEN-1], b1_eff_s[XLEN-1], full1_s[XLEN-1]);
`endif
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_seq.sv
// Scoreboard bench for arith_seq: one instance with CHUNK=8 (4 slices) and
// one with CHUNK=32 (single slice). Expected results are pushed when an
// operation is issued; per-instance monitors pop and compare on each
// consumed output.
module tb_arith_seq;

  typedef struct {
    logic [31:0] ar;
    logic [31:0] br;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_valid1, out_ready, c16;
  logic [2:0]  op;
  logic [31:0] src1, src2, now_pc;
  logic        in_ready, out_valid, in_ready1, out_valid1;
  logic [31:0] arith_result, branch_result, arith_result1, branch_result1;
  logic        ovf0, ovf1;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  arith_seq #(.XLEN(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .c16(c16), .src1(src1), .src2(src2), .now_pc(now_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .arith_result(arith_result), .branch_result(branch_result)
`ifdef ARITH_SEQ_OVF_EN
    , .arith_ovf(ovf0)
`endif
  );

  arith_seq #(.XLEN(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op), .c16(c16), .src1(src1), .src2(src2), .now_pc(now_pc),
    .out_valid(out_valid1), .out_ready(out_ready),
    .arith_result(arith_result1), .branch_result(branch_result1)
`ifdef ARITH_SEQ_OVF_EN
    , .arith_ovf(ovf1)
`endif
  );

`ifndef ARITH_SEQ_OVF_EN
  assign ovf0 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor for the 4-slice instance.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q0.size() == 0) begin
        check("unexpected_out0", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("arith_result0", arith_result, e.ar);
        check("branch_result0", branch_result, e.br);
`ifdef ARITH_SEQ_OVF_EN
        check("arith_ovf0", {31'd0, ovf0}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // Monitor for the single-slice instance.
  always @(negedge clk) begin
    if (out_valid1 === 1'b1 && out_ready === 1'b1) begin
      if (q1.size() == 0) begin
        check("unexpected_out1", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("arith_result1", arith_result1, e.ar);
        check("branch_result1", branch_result1, e.br);
`ifdef ARITH_SEQ_OVF_EN
        check("arith_ovf1", {31'd0, ovf1}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // Issue one operation, check its latency, and let it be consumed if
  // out_ready is high.
  task automatic run_op(input int which, input logic [2:0] op_i, input logic c16_i,
                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] pc,
                        input logic [31:0] ear, input logic [31:0] ebr, input logic eovf);
    exp_t e;
    int   cyc;
    int   lat_exp;
    e.ar = ear;
    e.br = ebr;
    e.ovf = eovf;
    lat_exp = (which == 1) ? 1 : 4;
    cyc = 0;
    while (((which == 1) ? in_ready1 : in_ready) !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20) check("ready_timeout", 32'd1, 32'd0);
    op = op_i; c16 = c16_i; src1 = s1; src2 = s2; now_pc = pc;
    if (which == 1) begin
      in_valid1 = 1'b1;
      q1.push_back(e);
    end else begin
      in_valid = 1'b1;
      q0.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valid1 = 1'b0;
    cyc = 0;
    while (((which == 1) ? out_valid1 : out_valid) !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat_exp));
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  // Watch n cycles; out_valid of the 4-slice instance must never assert.
  task automatic no_valid_for(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b1;
    op = 3'b000; c16 = 1'b0; src1 = 32'd0; src2 = 32'd0; now_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_arith", arith_result, 32'd0);
    check("rst_branch", branch_result, 32'd0);
    check("rst_ovf", {31'd0, ovf0}, 32'd0);

    // Directed operations: op, c16, src1, src2, now_pc -> arith, branch, ovf
    run_op(0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0000_0000, 32'h0, 1'b0);
    run_op(0, 3'b001, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h0, 32'h7FFF_FFFF, 32'h0, 1'b1);
    run_op(0, 3'b011, 1'b1, 32'h0000_0203, 32'h0000_0010, 32'h100, 32'h0000_0102, 32'h0000_0212, 1'b0);
    run_op(0, 3'b010, 1'b0, 32'h0000_1000, 32'h0000_0020, 32'h0, 32'h0000_1004, 32'h0000_1020, 1'b0);
    run_op(0, 3'b100, 1'b0, 32'h0000_0005, 32'h0000_0009, 32'h0, 32'h0000_0006, 32'h0000_000A, 1'b0);
    run_op(0, 3'b111, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h0, 32'h2345_6789, 32'h0, 1'b0);

    // Back-pressure: DONE held for 3 cycles with out_ready low
    out_ready = 1'b0;
    run_op(0, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h8000_0000, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_arith", arith_result, 32'h8000_0000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_valid", {31'd0, out_valid}, 32'd0);

    // Flush on the 2nd COMP cycle
    op = 3'b000; src1 = 32'h1; src2 = 32'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_arith_hold", arith_result, 32'h8000_0000);
    check("flush_branch_hold", branch_result, 32'h0);
    no_valid_for("flush_no_valid", 8);

    // Flush beats a simultaneous offer in IDLE
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_in_ready", {31'd0, in_ready}, 32'd1);
    no_valid_for("flush_accept_no_valid", 6);

    // Reset during COMP
    op = 3'b000; src1 = 32'h5; src2 = 32'h6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstcomp_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstcomp_valid", {31'd0, out_valid}, 32'd0);
    check("rstcomp_arith", arith_result, 32'h0);
    check("rstcomp_branch", branch_result, 32'h0);
    check("rstcomp_ovf", {31'd0, ovf0}, 32'd0);
    no_valid_for("rstcomp_no_valid", 8);

    // Normal operation resumes; carry ripple across the middle slices
    run_op(0, 3'b000, 1'b0, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 32'h0002_0000, 32'h0, 1'b0);

    // Single-slice instance: 1-cycle latency
    run_op(1, 3'b100, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0, 1'b1);
    run_op(1, 3'b001, 1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'hFFFF_FFFE, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
